// File: rtl/trivium_stream_ctrl.sv
// trivium_stream_ctrl: loads, warms up and steps a Trivium core, packing its bits LSB-first into valid/ready words
module trivium_stream_ctrl #(
    parameter int WARMUP_CYCLES = 1152,
    parameter int WORD_W = 32,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [79:0]       key,
    input  logic [79:0]       iv,
    input  logic [LEN_W-1:0]  num_words,
    output logic              busy,
    output logic              done,
    output logic              core_load,
    output logic [79:0]       core_key,
    output logic [79:0]       core_iv,
    output logic              core_step,
    output logic              core_warm,
    input  logic              core_z,
    output logic [WORD_W-1:0] ks_data,
    output logic              ks_valid,
    input  logic              ks_ready
);
    localparam int WC_W = $clog2(WARMUP_CYCLES) > 11 ? $clog2(WARMUP_CYCLES) : 11;
    localparam int BC_W = WORD_W > 2 ? $clog2(WORD_W) : 1;
    localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, WARMUP = 3'd2, STREAM = 3'd3, DRAIN = 3'd4;

    logic [2:0]        state;
    logic [WC_W-1:0]   warm_cnt;
    logic [BC_W-1:0]   bit_cnt;
    logic [LEN_W-1:0]  len;
    logic [LEN_W-1:0]  words;
    logic [WORD_W-1:0] collector;
    logic              pending;
    logic              out_free;
    logic              word_done;
    logic              last_word;
    logic              warm_last;

    always_comb begin
        busy      = state != IDLE;
        core_load = state == LOAD;
        core_warm = state == WARMUP;
        core_step = core_warm || (state == STREAM && !pending);
        out_free  = !ks_valid || ks_ready;
        word_done = state == STREAM && !pending && bit_cnt == BC_W'(WORD_W - 1);
        last_word = words + LEN_W'(1) == len;
        warm_last = warm_cnt == WC_W'(WARMUP_CYCLES - 1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            warm_cnt  <= '0;
            bit_cnt   <= '0;
            len       <= '0;
            words     <= '0;
            collector <= '0;
            pending   <= 1'b0;
            core_key  <= '0;
            core_iv   <= '0;
            ks_data   <= '0;
            ks_valid  <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state    <= IDLE;
            warm_cnt <= '0;
            bit_cnt  <= '0;
            words    <= '0;
            pending  <= 1'b0;
            ks_valid <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (ks_valid && ks_ready)
                ks_valid <= 1'b0;
            case (state)
                IDLE: if (start && num_words != '0) begin
                    core_key <= key;
                    core_iv  <= iv;
                    len      <= num_words;
                    state    <= LOAD;
                end
                LOAD: state <= WARMUP;
                WARMUP: begin
                    warm_cnt <= warm_last ? '0 : warm_cnt + WC_W'(1);
                    if (warm_last)
                        state <= STREAM;
                end
                STREAM: begin
                    if (pending && out_free) begin
                        ks_data  <= collector;
                        ks_valid <= 1'b1;
                        pending  <= 1'b0;
                    end else if (core_step) begin
                        collector[bit_cnt] <= core_z;
                        bit_cnt <= word_done ? '0 : bit_cnt + BC_W'(1);
                        if (word_done) begin
                            words <= words + LEN_W'(1);
                            // a finished word that cannot reach the output waits in the collector
                            if (out_free) begin
                                ks_data  <= {core_z, collector[WORD_W-2:0]};
                                ks_valid <= 1'b1;
                            end else
                                pending <= 1'b1;
                            if (last_word)
                                state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pending && out_free) begin
                        ks_data  <= collector;
                        ks_valid <= 1'b1;
                        pending  <= 1'b0;
                    end else if (!pending && ks_valid && ks_ready) begin
                        done  <= 1'b1;
                        words <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/trivium_stream_ctrl.md
Name: trivium_stream_ctrl

Overview:
- Sequencer for a Trivium keystream core: latches the key/IV for a request, issues the single-cycle state load, runs the fixed warm-up, then steps the core and packs output bits into words.
- Delivers keystream words over a valid/ready port with backpressure; the core is stalled, not dropped, when the consumer is slow.
- Sits between a host/command block and the core; the core holds no counters of its own.

Parameters:
- WARMUP_CYCLES, 1152, number of core_step cycles with core_warm=1 after load
- WORD_W, 32, keystream word width (bits per output word)
- LEN_W, 16, width of the requested word count

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request strobe; sampled only in IDLE
- abort  in  1  synchronous cancel, any state
- key  in  80  key, latched on accepted start
- iv  in  80  IV, latched on accepted start
- num_words  in  LEN_W  words to generate, latched on accepted start
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after last word accepted
- core_load  out  1  load core state from core_key/core_iv
- core_key  out  80  latched key
- core_iv  out  80  latched IV
- core_step  out  1  advance core one step
- core_warm  out  1  qualifies core_step as warm-up (no output)
- core_z  in  1  core output bit for current (pre-step) state
- ks_data  out  WORD_W  keystream word
- ks_valid  out  1  ks_data valid
- ks_ready  in  1  consumer accepts word when ks_valid & ks_ready

Behaviour:
- Reset values: state IDLE; busy, done, core_load, core_step, core_warm, ks_valid = 0; ks_data, core_key, core_iv = 0; all counters 0.
- States: IDLE, LOAD, WARMUP, STREAM, DRAIN.
- IDLE: start=1 and num_words!=0 at an edge → latch key/iv/num_words, go to LOAD. start with num_words=0 is ignored; no done pulse. start outside IDLE is ignored.
- LOAD: exactly one cycle with core_load=1, then WARMUP.
- WARMUP: core_step=1 and core_warm=1 for exactly WARMUP_CYCLES consecutive cycles, using an 11-bit-or-wider counter, then STREAM.
- Timing: with start accepted at edge E0, LOAD occupies cycle 1, WARMUP occupies cycles 2..1153, and the first STREAM step is in cycle 1154.
- STREAM:
  - core_warm=0. In each cycle with core_step=1, core_z is captured into collector bit [bit_cnt]; the first bit goes to bit 0 (LSB-first).
  - After WORD_W bits the word is complete. If the output register is empty, or is being accepted in the same cycle, the word moves to ks_data and ks_valid=1 next cycle.
  - Otherwise the word is held in the collector with a pending flag set, and core_step=0 (stall) until the transfer happens. The core is never stepped while pending=1.
  - Result: at most 2 words are buffered (collector + output); no bit is lost or duplicated across a stall.
  - When words_collected reaches the latched num_words, stepping stops and the FSM goes to DRAIN.
- DRAIN:
  - core_step=0.
  - Any pending word transfers to the output register as soon as it frees.
  - When the last word is accepted (ks_valid & ks_ready), done=1 for one cycle, then IDLE.
- ks_valid/ks_data hold stable until accepted. ks_valid drops the cycle after acceptance unless a new word is loaded in the same edge.
- abort=1 (synchronous, highest priority after reset):
  - Next state IDLE; ks_valid and pending cleared; all counters cleared; no done pulse.
  - An abort in the same cycle as start in IDLE wins: the request is dropped.
- Async reset mid-operation returns everything to reset values immediately; the core's own state is don't-care until the next core_load.
- Latency: with ks_ready held high and WORD_W=32, the first word's 32 steps occupy cycles 1154..1185 and ks_valid=1 in cycle 1186. Subsequent words follow every 32 cycles with no bubbles.

Test Plan:
- Basic: stub core_z alternates 1,0,1,… starting in cycle 1154; start with num_words=1, ks_ready=1 → core_load only in cycle 1; core_step&core_warm in exactly 1152 cycles; ks_data=0x55555555 valid in cycle 1186; done pulse in cycle 1187; busy low afterwards.
- Backpressure: num_words=3, stub core_z=bit-count LSB pattern, ks_ready=0 for 100 cycles after first valid → core_step drops once collector fills, total core_step high exactly 1152+96 cycles, three words delivered identical to the ks_ready=1 run.
- Zero / busy start: start with num_words=0 → busy stays 0, no core_load; start pulsed during WARMUP → ignored, warm-up count unchanged.
- Abort: assert abort during STREAM after 10 bits of word 2 → ks_valid=0 next cycle, IDLE, no done; new start then runs a full 1152-cycle warm-up again.
- Async reset: assert reset in DRAIN with ks_valid=1 → all outputs 0 immediately; after release, a fresh request behaves as in the basic test.
- Simultaneous accept and complete: consumer accepts word N in the same cycle the collector completes word N+1 → word N+1 on ks_data next cycle, no stall cycle inserted.
